wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between in-order pipeline writeback and a multi-cycle MDU (mul/div) result stream. Pipeline writeback always has priority and is never back-pressured. MDU results queue in a small FIFO and drain into free write-port slots. If the FIFO head starves, the block requests a WB bubble. It also keeps a per-register pending scoreboard that decode uses for RAW stalls.

Parameters:
WIDTH, 32, data width of the write port
DEPTH, 2, MDU result FIFO entries (power of two, >=2)
STARVE_LIMIT, 8, cycles the FIFO head may wait before a bubble is requested

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
wb_reg_wen_i  in  1  pipeline WB write enable
wb_rd_i  in  5  pipeline WB destination
wb_data_i  in  WIDTH  pipeline WB data
mdu_issue_i  in  1  MDU op issued this cycle (sets scoreboard)
mdu_issue_rd_i  in  5  destination of issued MDU op
mdu_valid_i  in  1  MDU result valid
mdu_rd_i  in  5  MDU result destination
mdu_data_i  in  WIDTH  MDU result data
mdu_ready_o  out  1  FIFO can accept a result
rf_wen_o  out  1  register-file write enable
rf_rd_o  out  5  register-file write address
rf_wdata_o  out  WIDTH  register-file write data
wb_bubble_req_o  out  1  request that WB present a non-writing slot
busy_o  out  32  pending-MDU-write bit per register (bit 0 always 0)

Behaviour:
- Reset (rst_n=0 at clk edge): FIFO empty, pointers/count 0, starve counter 0, FSM=IDLE, busy_o=0. Outputs: mdu_ready_o=1, rf_wen_o=0 unless the pipe writes, wb_bubble_req_o=0.
- Pipe slot: pipe_wr = wb_reg_wen_i && wb_rd_i!=0. If pipe_wr: rf_* = wb_* combinationally, 0-cycle latency, no FIFO dequeue.
- FIFO grant: grant = !pipe_wr && !empty. rf_wen_o=1, rf_rd_o/rf_wdata_o = FIFO head, head dequeued at edge.
- Idle port: rf_wen_o=0, rf_rd_o=0, rf_wdata_o=0.
- Enqueue: mdu_ready_o = !full, registered from count and independent of grant.
  - Handshake fires on mdu_valid_i && mdu_ready_o.
  - rd=0 results are accepted and dropped, not enqueued.
  - No bypass: an enqueued result reaches the port no earlier than the next cycle.
  - Simultaneous enqueue and dequeue leaves count unchanged; pointers wrap mod DEPTH.
- FSM:
  - IDLE (empty): enqueue -> PEND.
  - PEND: starve counter increments each cycle the head is not granted and resets to 0 on every grant. Counter reaching STARVE_LIMIT-1 without a grant -> STARVE. Grant that empties the FIFO with no enqueue -> IDLE.
  - STARVE: wb_bubble_req_o=1, registered and asserted only in this state. Held until a grant occurs. Then -> PEND if entries remain or an enqueue happens that cycle, else IDLE. Counter clears on exit.
- Scoreboard:
  - Set busy[rd] on mdu_issue_i (rd!=0).
  - Clear busy[rd] on a FIFO grant for that rd, and at enqueue for a dropped rd=0 result (no-op).
  - Same-cycle set and clear of the same rd: set wins (newer op).
  - A pipe write to a busy rd does not clear it.
- Reset mid-operation discards all FIFO contents and pending bits; nothing is written at or after the reset edge.
- Widths: count is clog2(DEPTH)+1 bits; starve counter is clog2(STARVE_LIMIT)+1 bits and saturates.

Decomposition:
- Shared package/define file: FSM state encoding (IDLE/PEND/STARVE), register-index width 5, x0 constant, and the wb_valD_sel encodings already used by writeback.
- One natural sub-module: wb_result_fifo (DEPTH-entry sync FIFO of {rd, data}, exposing full/empty/head).
- Arbitration, FSM and scoreboard stay in the top.

Test Plan:
- Reset, then MDU result rd=5 data=0xA5 with pipe idle -> enqueued at cycle 0; rf_wen_o=1, rf_rd_o=5, rf_wdata_o=0xA5 at cycle 1; busy_o[5] clears after that edge.
- Pipe writes every cycle (rd=3) while MDU pushes 3 results -> rf always shows pipe data. mdu_ready_o drops after 2 accepts. wb_bubble_req_o rises after 8 ungranted cycles; first pipe wen=0 cycle writes the head, and bubble_req deasserts the next cycle.
- MDU result rd=0 -> handshake completes, FIFO stays empty, no rf write, FSM stays IDLE.
- mdu_issue rd=7 in the same cycle as FIFO grant of rd=7 -> busy_o[7] remains 1.
- Full FIFO with grant and mdu_valid in the same cycle -> no enqueue (ready=0), count 2->1, ready=1 the next cycle.
- rst_n low for one cycle with 2 entries pending and FSM=STARVE -> next cycle empty, busy_o=0, bubble_req=0, no rf write.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] X0 = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        STARVE = 2'd2
    } arb_state_e;

    // Writeback value-select encodings shared with the writeback stage.
    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2,
        WB_SEL_CSR = 2'd3
    } wb_vald_sel_e;

endpackage

// File: rtl/wb_port_arbiter_result_fifo.sv
// Small synchronous FIFO holding {rd, data} MDU results awaiting a write-port slot.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [REG_W-1:0]         push_rd,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [REG_W-1:0]         head_rd,
    output logic [WIDTH-1:0]         head_data
);

    localparam int AW = $clog2(DEPTH);

    logic [REG_W-1:0] rd_mem   [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;

    // Entry storage; contents are meaningless while empty so they are not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign full      = (cnt == (AW+1)'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign head_rd   = rd_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, queued MDU results fill idle slots.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_reg_wen_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic [WIDTH-1:0] wb_data_i,
    input  logic             mdu_issue_i,
    input  logic [REG_W-1:0] mdu_issue_rd_i,
    input  logic             mdu_valid_i,
    input  logic [REG_W-1:0] mdu_rd_i,
    input  logic [WIDTH-1:0] mdu_data_i,
    output logic             mdu_ready_o,
    output logic             rf_wen_o,
    output logic [REG_W-1:0] rf_rd_o,
    output logic [WIDTH-1:0] rf_wdata_o,
    output logic             wb_bubble_req_o,
    output logic [31:0]      busy_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    logic             pipe_wr;
    logic             accept;
    logic             enq;
    logic             grant;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [REG_W-1:0] head_rd;
    logic [WIDTH-1:0] head_data;

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [SW-1:0]    starve_cnt;
    logic [SW-1:0]    starve_cnt_nxt;
    logic [31:0]      busy;
    logic [31:0]      busy_nxt;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (&v) ? v : v + SW'(1);
    endfunction

    // Grant is held off during reset so nothing from the FIFO lands at the reset edge.
    assign pipe_wr     = wb_reg_wen_i && (wb_rd_i != X0);
    assign mdu_ready_o = !full;
    assign accept      = mdu_valid_i && mdu_ready_o;
    assign enq         = accept && (mdu_rd_i != X0);
    assign grant       = rst_n && !pipe_wr && !empty;

    wb_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (enq),
        .push_rd   (mdu_rd_i),
        .push_data (mdu_data_i),
        .pop       (grant),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head_rd   (head_rd),
        .head_data (head_data)
    );

    // Write-port mux: pipeline slot, else FIFO head, else an all-zero idle slot.
    always_comb begin
        rf_wen_o   = 1'b0;
        rf_rd_o    = X0;
        rf_wdata_o = '0;
        if (pipe_wr) begin
            rf_wen_o   = 1'b1;
            rf_rd_o    = wb_rd_i;
            rf_wdata_o = wb_data_i;
        end else if (grant) begin
            rf_wen_o   = 1'b1;
            rf_rd_o    = head_rd;
            rf_wdata_o = head_data;
        end
    end

    // Starvation FSM next-state; the last entry leaving with no refill returns to IDLE.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = starve_cnt;
        case (state)
            IDLE: begin
                starve_cnt_nxt = '0;
                if (enq) state_nxt = PEND;
            end
            PEND: begin
                if (grant) begin
                    starve_cnt_nxt = '0;
                    if (count == CW'(1) && !enq) state_nxt = IDLE;
                end else begin
                    starve_cnt_nxt = sat_inc(starve_cnt);
                    if (starve_cnt == SW'(STARVE_LIMIT - 1)) state_nxt = STARVE;
                end
            end
            STARVE: begin
                if (grant) begin
                    starve_cnt_nxt = '0;
                    state_nxt      = (count != CW'(1) || enq) ? PEND : IDLE;
                end else begin
                    starve_cnt_nxt = sat_inc(starve_cnt);
                end
            end
            default: begin
                state_nxt      = IDLE;
                starve_cnt_nxt = '0;
            end
        endcase
    end

    // Pending-write scoreboard: grant clears, a newer issue to the same rd wins.
    always_comb begin
        busy_nxt = busy;
        if (grant) busy_nxt[head_rd] = 1'b0;
        if (mdu_issue_i && mdu_issue_rd_i != X0) busy_nxt[mdu_issue_rd_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // State, starve counter and scoreboard registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            busy       <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
            busy       <= busy_nxt;
        end
    end

    assign wb_bubble_req_o = (state == STARVE);
    assign busy_o          = busy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed stimulus with a write-port scoreboard.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_reg_wen_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        mdu_issue_i;
    logic [4:0]  mdu_issue_rd_i;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [31:0] mdu_data_i;
    logic        mdu_ready_o;
    logic        rf_wen_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_wdata_o;
    logic        wb_bubble_req_o;
    logic [31:0] busy_o;

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  cyc    = 0;
    int  n_chk  = 0;
    int  n_fail = 0;

    wb_port_arbiter #(
        .WIDTH        (32),
        .DEPTH        (2),
        .STARVE_LIMIT (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_reg_wen_i    (wb_reg_wen_i),
        .wb_rd_i         (wb_rd_i),
        .wb_data_i       (wb_data_i),
        .mdu_issue_i     (mdu_issue_i),
        .mdu_issue_rd_i  (mdu_issue_rd_i),
        .mdu_valid_i     (mdu_valid_i),
        .mdu_rd_i        (mdu_rd_i),
        .mdu_data_i      (mdu_data_i),
        .mdu_ready_o     (mdu_ready_o),
        .rf_wen_o        (rf_wen_o),
        .rf_rd_o         (rf_rd_o),
        .rf_wdata_o      (rf_wdata_o),
        .wb_bubble_req_o (wb_bubble_req_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every write-port slot is matched against the expected-write queue.
    always @(negedge clk) begin
        wr_t e;
        if (rf_wen_o) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h at cycle %0d, expected no write",
                         rf_rd_o, rf_wdata_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.rd != rf_rd_o || e.data != rf_wdata_o) begin
                    n_fail++;
                    $display("FAIL rf_write: got cyc=%0d rd=%0d data=0x%0h, expected cyc=%0d rd=%0d data=0x%0h",
                             cyc, rf_rd_o, rf_wdata_o, e.cyc, e.rd, e.data);
                end
            end
        end else begin
            n_chk++;
            if (rf_rd_o != 5'd0 || rf_wdata_o != 32'd0) begin
                n_fail++;
                $display("FAIL idle_port: got rd=%0d data=0x%0h, expected 0/0 at cycle %0d",
                         rf_rd_o, rf_wdata_o, cyc);
            end
        end
    end

    task automatic idle_in();
        wb_reg_wen_i   = 1'b0;
        wb_rd_i        = 5'd0;
        wb_data_i      = 32'd0;
        mdu_issue_i    = 1'b0;
        mdu_issue_rd_i = 5'd0;
        mdu_valid_i    = 1'b0;
        mdu_rd_i       = 5'd0;
        mdu_data_i     = 32'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic exp_wr(input logic [4:0] rd, input logic [31:0] d);
        wr_t e;
        e.cyc  = cyc;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] d);
        wb_reg_wen_i = 1'b1;
        wb_rd_i      = rd;
        wb_data_i    = d;
        exp_wr(rd, d);
    endtask

    task automatic mdu_push(input logic [4:0] rd, input logic [31:0] d);
        mdu_valid_i = 1'b1;
        mdu_rd_i    = rd;
        mdu_data_i  = d;
    endtask

    task automatic mdu_issue(input logic [4:0] rd);
        mdu_issue_i    = 1'b1;
        mdu_issue_rd_i = rd;
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        mid();
        chk("reset_ready", 32'(mdu_ready_o), 32'd1);
        chk("reset_wen", 32'(rf_wen_o), 32'd0);
        chk("reset_bubble", 32'(wb_bubble_req_o), 32'd0);
        chk("reset_busy", busy_o, 32'd0);

        // Single MDU result on an idle pipe
        next_cycle(); rst_n = 1'b1;
        mdu_issue(5'd5);
        next_cycle();
        mdu_push(5'd5, 32'hA5);
        mid();
        chk("t1_busy5_set", 32'(busy_o[5]), 32'd1);
        chk("t1_ready", 32'(mdu_ready_o), 32'd1);
        next_cycle();
        exp_wr(5'd5, 32'hA5);
        mid();
        chk("t1_busy5_before_grant_edge", 32'(busy_o[5]), 32'd1);
        next_cycle();
        mid();
        chk("t1_busy5_cleared", 32'(busy_o[5]), 32'd0);
        chk("t1_bubble", 32'(wb_bubble_req_o), 32'd0);

        // rd=0 result: accepted and dropped
        next_cycle();
        mdu_push(5'd0, 32'hDEAD);
        mid();
        chk("t3_ready_rd0", 32'(mdu_ready_o), 32'd1);
        next_cycle();
        mid();
        chk("t3_ready_after", 32'(mdu_ready_o), 32'd1);
        chk("t3_bubble", 32'(wb_bubble_req_o), 32'd0);

        // Pipe owns every slot while three results arrive; starvation then bubble
        next_cycle();
        drive_pipe(5'd3, 32'h3000);
        mdu_push(5'd10, 32'h100);
        mid();
        chk("t2_ready_c0", 32'(mdu_ready_o), 32'd1);
        next_cycle();
        drive_pipe(5'd3, 32'h3001);
        mdu_push(5'd11, 32'h101);
        mid();
        chk("t2_ready_c1", 32'(mdu_ready_o), 32'd1);
        for (int k = 2; k <= 9; k++) begin
            next_cycle();
            drive_pipe(5'd3, 32'h3000 + 32'(k));
            mdu_push(5'd12, 32'h102);
            mid();
            chk("t2_ready_full", 32'(mdu_ready_o), 32'd0);
            chk("t2_bubble", 32'(wb_bubble_req_o), 32'(k == 9));
        end
        next_cycle();
        mdu_push(5'd12, 32'h102);
        exp_wr(5'd10, 32'h100);
        mid();
        chk("t5_ready_full_grant", 32'(mdu_ready_o), 32'd0);
        chk("t2_bubble_grant_cycle", 32'(wb_bubble_req_o), 32'd1);
        next_cycle();
        mdu_push(5'd12, 32'h102);
        exp_wr(5'd11, 32'h101);
        mid();
        chk("t5_ready_after_grant", 32'(mdu_ready_o), 32'd1);
        chk("t2_bubble_dropped", 32'(wb_bubble_req_o), 32'd0);
        next_cycle();
        exp_wr(5'd12, 32'h102);
        mid();
        chk("t2_bubble_c12", 32'(wb_bubble_req_o), 32'd0);
        next_cycle();
        mid();
        chk("t2_ready_drained", 32'(mdu_ready_o), 32'd1);

        // Issue and grant of the same rd in one cycle: set wins
        next_cycle();
        mdu_issue(5'd7);
        next_cycle();
        mdu_push(5'd7, 32'h77);
        mid();
        chk("t4_busy7_set", 32'(busy_o[7]), 32'd1);
        next_cycle();
        mdu_issue(5'd7);
        exp_wr(5'd7, 32'h77);
        next_cycle();
        drive_pipe(5'd7, 32'h55);
        mid();
        chk("t4_busy7_set_wins", 32'(busy_o[7]), 32'd1);
        next_cycle();
        mdu_push(5'd7, 32'h78);
        mid();
        chk("t4_pipe_no_clear", 32'(busy_o[7]), 32'd1);
        next_cycle();
        exp_wr(5'd7, 32'h78);
        next_cycle();
        mid();
        chk("t4_busy7_cleared", 32'(busy_o[7]), 32'd0);

        // Reset while starving with two entries queued
        for (int k = 0; k <= 9; k++) begin
            next_cycle();
            drive_pipe(5'd3, 32'h4000 + 32'(k));
            if (k == 0) begin mdu_issue(5'd20); mdu_push(5'd20, 32'h200); end
            if (k == 1) begin mdu_issue(5'd21); mdu_push(5'd21, 32'h201); end
        end
        mid();
        chk("t6_bubble_starve", 32'(wb_bubble_req_o), 32'd1);
        chk("t6_busy_pending", busy_o, 32'h0030_0000);
        next_cycle();
        rst_n = 1'b0;
        mid();
        chk("t6_no_write_in_reset", 32'(rf_wen_o), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        mid();
        chk("t6_busy_cleared", busy_o, 32'd0);
        chk("t6_bubble_cleared", 32'(wb_bubble_req_o), 32'd0);
        chk("t6_ready", 32'(mdu_ready_o), 32'd1);
        chk("t6_no_write_after", 32'(rf_wen_o), 32'd0);
        next_cycle();
        mid();
        chk("t6_still_empty", 32'(rf_wen_o), 32'd0);

        next_cycle();
        mid();
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
